// File: rtl/riscv_icache_pkg.sv
// Shared instruction-cache types: FSM state encoding and default geometry.
package riscv_icache_pkg;

    localparam int unsigned DEF_LINE_WIDTH = 512;
    localparam int unsigned DEF_WORD_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_SET_DEPTH  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } lfb_state_e;

endpackage

// File: rtl/icache_addr_split.sv
// Splits a byte address into word index, set and tag; also yields the
// refill base address (word- or line-aligned) and the first refill slot.
module icache_addr_split
    import riscv_icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned SET_DEPTH  = DEF_SET_DEPTH,
    parameter bit          CRIT_FIRST = 1'b0,
    localparam int unsigned OFF_BITS  = $clog2(LINE_WIDTH / 8),
    localparam int unsigned BYTE_BITS = $clog2(WORD_WIDTH / 8),
    localparam int unsigned IDX_BITS  = OFF_BITS - BYTE_BITS,
    localparam int unsigned SET_BITS  = $clog2(SET_DEPTH),
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - SET_BITS - OFF_BITS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_BITS-1:0]   start_idx,
    output logic [SET_BITS-1:0]   set_idx,
    output logic [TAG_BITS-1:0]   tag,
    output logic [ADDR_WIDTH-1:0] base_addr
);

    localparam int unsigned ALIGN_BITS = CRIT_FIRST ? BYTE_BITS : OFF_BITS;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

    assign start_idx = CRIT_FIRST ? addr[OFF_BITS-1:BYTE_BITS] : '0;
    assign set_idx   = addr[OFF_BITS+SET_BITS-1:OFF_BITS];
    assign tag       = addr[ADDR_WIDTH-1:OFF_BITS+SET_BITS];
    assign base_addr = addr & ALIGN_MASK;

endmodule

// File: rtl/line_fill_buffer.sv
// Instruction-cache line fill buffer: one outstanding miss, beat-wise refill.
// Define LFB_CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module line_fill_buffer
    import riscv_icache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned SET_DEPTH  = DEF_SET_DEPTH,
    localparam int unsigned WPL       = LINE_WIDTH / WORD_WIDTH,
    localparam int unsigned IDX_BITS  = $clog2(WPL),
    localparam int unsigned OFF_BITS  = $clog2(LINE_WIDTH / 8),
    localparam int unsigned SET_BITS  = $clog2(SET_DEPTH),
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - SET_BITS - OFF_BITS
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  MISS_VALID,
    input  logic [ADDR_WIDTH-1:0] MISS_ADDR,
    output logic                  MISS_READY,
    output logic                  MEM_REQ_VALID,
    output logic [ADDR_WIDTH-1:0] MEM_REQ_ADDR,
    input  logic                  MEM_REQ_READY,
    input  logic                  MEM_RSP_VALID,
    input  logic [WORD_WIDTH-1:0] MEM_RSP_DATA,
    output logic                  MEM_RSP_READY,
    output logic                  LINE_WRITE_ENABLE,
    output logic [SET_BITS-1:0]   LINE_WRITE_ADDRESS,
    output logic [LINE_WIDTH-1:0] LINE_DATA,
    output logic [TAG_BITS-1:0]   LINE_TAG,
    output logic                  FILL_DONE,
    output logic                  CRIT_WORD_VALID,
    output logic [WORD_WIDTH-1:0] CRIT_WORD
);

`ifdef LFB_CRITICAL_WORD_FIRST_EN
    localparam bit CRIT_FIRST = 1'b1;
`else
    localparam bit CRIT_FIRST = 1'b0;
`endif

    lfb_state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [IDX_BITS-1:0]          cnt_q, cnt_d;
    logic                         miss_ready_q;
    logic                         req_valid_q;
    logic                         rsp_ready_q;
    logic                         wr_en_q;
    logic [WPL-1:0][WORD_WIDTH-1:0] line_q;

    logic [IDX_BITS-1:0]          start_idx;
    logic [IDX_BITS-1:0]          slot;
    logic [SET_BITS-1:0]          set_idx;
    logic [TAG_BITS-1:0]          tag;
    logic [ADDR_WIDTH-1:0]        base_addr;
    logic                         beat;

    icache_addr_split #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .SET_DEPTH  (SET_DEPTH),
        .CRIT_FIRST (CRIT_FIRST)
    ) u_split (
        .addr      (addr_q),
        .start_idx (start_idx),
        .set_idx   (set_idx),
        .tag       (tag),
        .base_addr (base_addr)
    );

    assign beat = rsp_ready_q & MEM_RSP_VALID;
    // Slot arithmetic wraps naturally because WPL is a power of two.
    assign slot = start_idx + cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_ready_q && MISS_VALID) begin
                    addr_d  = MISS_ADDR;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_valid_q && MEM_REQ_READY) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == IDX_BITS'(WPL - 1)) state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            rsp_ready_q  <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            miss_ready_q <= (state_d == ST_IDLE);
            req_valid_q  <= (state_d == ST_REQ);
            rsp_ready_q  <= (state_d == ST_FILL);
            wr_en_q      <= (state_d == ST_WRITE);
        end
    end

    // Data is only consumed with LINE_WRITE_ENABLE, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (beat) line_q[slot] <= MEM_RSP_DATA;
    end

    assign MISS_READY         = miss_ready_q;
    assign MEM_REQ_VALID      = req_valid_q;
    assign MEM_REQ_ADDR       = base_addr;
    assign MEM_RSP_READY      = rsp_ready_q;
    assign LINE_WRITE_ENABLE  = wr_en_q;
    assign FILL_DONE          = wr_en_q;
    assign LINE_WRITE_ADDRESS = set_idx;
    assign LINE_TAG           = tag;
    assign LINE_DATA          = line_q;

`ifdef LFB_CRITICAL_WORD_FIRST_EN
    assign CRIT_WORD_VALID = beat && (cnt_q == '0);
    assign CRIT_WORD       = CRIT_WORD_VALID ? MEM_RSP_DATA : '0;
`else
    assign CRIT_WORD_VALID = 1'b0;
    assign CRIT_WORD       = '0;
`endif

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: LINE_FILL_BUFFER

Interface
REQ-001 Parameter LINE_WIDTH, default 512, SHALL set cache line width in bits; it matches the instruction-cache data memory width.
REQ-002 Parameter WORD_WIDTH, default 32, SHALL set refill beat width; LINE_WIDTH/WORD_WIDTH (WPL, default 16) SHALL be a power of two.
REQ-003 Parameter ADDR_WIDTH, default 32, SHALL set byte address width.
REQ-004 Parameter SET_DEPTH, default 512, SHALL set line count; SET_BITS = $clog2(SET_DEPTH).
REQ-005 Ports (name direction width meaning), one clock; reset is asynchronous and active-low:
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 MISS_VALID  in  1  cache miss request; MISS_ADDR  in  ADDR_WIDTH  missing byte address; MISS_READY  out  1  miss accepted.
REQ-009 MEM_REQ_VALID  out  1; MEM_REQ_ADDR  out  ADDR_WIDTH; MEM_REQ_READY  in  1  lower-memory request channel.
REQ-010 MEM_RSP_VALID  in  1; MEM_RSP_DATA  in  WORD_WIDTH; MEM_RSP_READY  out  1  lower-memory response channel, one word per beat.
REQ-011 LINE_WRITE_ENABLE  out  1; LINE_WRITE_ADDRESS  out  SET_BITS; LINE_DATA  out  LINE_WIDTH  write port into line memory.
REQ-012 LINE_TAG  out  ADDR_WIDTH-SET_BITS-OFF_BITS  tag of line being written; FILL_DONE  out  1  one-cycle completion pulse.
REQ-013 CRIT_WORD_VALID  out  1; CRIT_WORD  out  WORD_WIDTH  early-forwarded missed word (see Configuration).

Function
REQ-014 Address split SHALL be: OFF_BITS=$clog2(LINE_WIDTH/8) byte offset, word index = bits [OFF_BITS-1:$clog2(WORD_WIDTH/8)], set = next SET_BITS, tag = remaining MSBs.
REQ-015 FSM states SHALL be IDLE, REQ, FILL, WRITE.
REQ-016 IDLE: MISS_READY=1; MISS_VALID&MISS_READY SHALL capture MISS_ADDR and go to REQ next cycle.
REQ-017 REQ: MEM_REQ_VALID=1, MEM_REQ_ADDR held stable until MEM_REQ_READY; handshake SHALL move to FILL.
REQ-018 FILL: MEM_RSP_READY=1; each MEM_RSP_VALID beat SHALL store MEM_RSP_DATA at slot (start+beat_count) mod WPL, beat_count 0..WPL-1.
REQ-019 Beat WPL-1 accepted SHALL move to WRITE; beat counter SHALL wrap to 0.
REQ-020 WRITE: exactly one cycle LINE_WRITE_ENABLE=1 and FILL_DONE=1 with LINE_WRITE_ADDRESS=captured set, LINE_TAG=captured tag, LINE_DATA=assembled line (word 0 in LSBs); then IDLE.
REQ-021 MISS_READY, MEM_REQ_VALID, MEM_RSP_READY SHALL be 0 outside IDLE, REQ, FILL respectively; MISS_VALID and MEM_RSP_VALID SHALL be ignored then.
REQ-022 Minimum miss-accept-to-write latency SHALL be WPL+2 cycles (REQ 1, FILL WPL, WRITE 1) with zero-wait memory.
REQ-023 Response stalls (MEM_RSP_VALID=0) SHALL hold state and counter; no timeout.
REQ-024 Back-to-back misses: a miss MAY be accepted the cycle after WRITE (IDLE); no overlap of fills.

Reset
REQ-025 RSTN low SHALL force IDLE, beat counter 0, and all outputs 0 except MISS_READY=1 after deassertion; mid-fill reset SHALL discard partial line with no write.
REQ-026 Line data register need not be reset; LINE_DATA SHALL be ignored unless LINE_WRITE_ENABLE=1.

Configuration
REQ-027 Macro LFB_CRITICAL_WORD_FIRST_EN defined: MEM_REQ_ADDR = word-aligned MISS_ADDR, start = missed word index, beats wrap mod WPL; first beat SHALL pulse CRIT_WORD_VALID=1 with CRIT_WORD=MEM_RSP_DATA same cycle.
REQ-028 Macro undefined: MEM_REQ_ADDR = line-aligned MISS_ADDR, start = 0, CRIT_WORD_VALID and CRIT_WORD tied 0.

Structure
REQ-029 Shared package RISCV_ICACHE_PKG SHALL hold the FSM state encoding and default width/depth constants.
REQ-030 Address field extraction SHALL be one sub-module ICACHE_ADDR_SPLIT, reused by the cache controller; no other sub-modules.

Verification
REQ-031 Reset then MISS_ADDR=0x0000_1040, zero-wait memory, words 0x0..0xF -> MEM_REQ_ADDR=0x1040, write at cycle 18 after accept, set=0x041, LINE_DATA word i = i, FILL_DONE one pulse.
REQ-032 With LFB_CRITICAL_WORD_FIRST_EN, MISS_ADDR=0x0000_1074 (word 13) -> MEM_REQ_ADDR=0x1074, first beat to slot 13 with CRIT_WORD_VALID, wrap 14,15,0..12, line equals REQ-031 ordering.
REQ-033 MEM_REQ_READY low 5 cycles, MEM_RSP_VALID gaps of 3 cycles every beat -> address stable, no lost/duplicated word, write only after 16th beat.
REQ-034 RSTN low after 7 beats, then new miss -> no LINE_WRITE_ENABLE for aborted fill; new fill completes correctly from beat 0.
REQ-035 MISS_VALID held high continuously, MEM_RSP_VALID asserted in IDLE/REQ -> MISS_READY only in IDLE, spurious beats not stored, two consecutive fills separated by one IDLE cycle.
